// File: rtl/uart_rx_word32.sv
`default_nettype none
// ============================================================================
// uart_rx_word32 : 8N1 UART receiver assembling four bytes into a 32-bit word
// Rev 1.0
// ============================================================================
module uart_rx_word32 #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        rx,
  output logic [31:0] data,
  output logic        done,
  output logic        frame_err,
  output logic        busy
);

  localparam int CNT_MAX = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] c_half_last = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] c_tmo_last  = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_rx_meta;
  logic             r_rx_s;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [1:0]       r_byte_idx;
  logic [7:0]       r_shift;
  logic [23:0]      r_shadow;
  logic [31:0]      r_data;
  logic             r_done;
  logic             r_frame_err;

  logic w_cnt_clr;
  logic w_start_ok;
  logic w_data_smp;
  logic w_stop_ok;
  logic w_stop_bad;
  logic w_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_cnt_clr    = 1'b0;
    w_start_ok   = 1'b0;
    w_data_smp   = 1'b0;
    w_stop_ok    = 1'b0;
    w_stop_bad   = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable && !r_rx_s) begin
          w_next_state = S_START;
          w_cnt_clr    = 1'b1;
        end else if (r_byte_idx != 2'd0 && r_cnt == c_tmo_last) begin
          w_timeout = 1'b1;
        end
      end
      S_START: begin
        if (r_cnt == c_half_last) begin
          w_cnt_clr = 1'b1;
          if (!r_rx_s) begin
            w_next_state = S_DATA;
            w_start_ok   = 1'b1;
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (r_cnt == c_bit_last) begin
          w_cnt_clr  = 1'b1;
          w_data_smp = 1'b1;
          if (r_bit_idx == 3'd7) w_next_state = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cnt == c_bit_last) begin
          w_cnt_clr = 1'b1;
          if (r_rx_s) begin
            w_stop_ok    = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_stop_bad   = 1'b1;
            w_next_state = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (r_rx_s) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
    // Disable overrides every state and suppresses any error strobe.
    if (!enable) begin
      w_next_state = S_IDLE;
      w_stop_bad   = 1'b0;
      w_timeout    = 1'b0;
      w_stop_ok    = 1'b0;
      w_start_ok   = 1'b0;
      w_data_smp   = 1'b0;
    end
  end

  // One counter serves both bit timing and the inter-byte timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!enable || w_cnt_clr || w_timeout) begin
      r_cnt <= '0;
    end else if (r_state == S_BREAK || (r_state == S_IDLE && r_byte_idx == 2'd0)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_cnt_one;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_idx   <= 3'd0;
      r_byte_idx  <= 2'd0;
      r_shift     <= 8'd0;
      r_shadow    <= 24'd0;
      r_data      <= 32'd0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (!enable) begin
        r_bit_idx  <= 3'd0;
        r_byte_idx <= 2'd0;
        r_done     <= 1'b0;
      end else begin
        if (w_start_ok) begin
          r_bit_idx <= 3'd0;
          if (r_byte_idx == 2'd0) r_done <= 1'b0;
        end
        if (w_data_smp) begin
          r_shift   <= {r_rx_s, r_shift[7:1]};
          r_bit_idx <= r_bit_idx + 3'd1;
        end
        if (w_stop_ok) begin
          if (r_byte_idx == 2'd3) begin
            r_data     <= {r_shift, r_shadow};
            r_done     <= 1'b1;
            r_byte_idx <= 2'd0;
          end else begin
            case (r_byte_idx)
              2'd0:    r_shadow[7:0]   <= r_shift;
              2'd1:    r_shadow[15:8]  <= r_shift;
              default: r_shadow[23:16] <= r_shift;
            endcase
            r_byte_idx <= r_byte_idx + 2'd1;
          end
        end
        if (w_stop_bad || w_timeout) begin
          r_frame_err <= 1'b1;
          r_byte_idx  <= 2'd0;
        end
      end
    end
  end

  assign data      = r_data;
  assign done      = r_done;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != S_IDLE) || (r_byte_idx != 2'd0);

endmodule
`default_nettype wire

// File: doc/uart_rx_word32.md
Name: uart_rx_word32

Overview:
Serial challenge receiver at the front of the PUF datapath. Receives four 8N1 UART bytes on rx and assembles them into one 32-bit word. Presents the word atomically with a done level that the binary-to-Gray stage, the PUF trigger and the TX enable delay chain consume. Adds framing-error detection and inter-byte timeout so a corrupted frame never produces a challenge.

Parameters:
CLKS_PER_BIT, 10416, clk cycles per UART bit (100 MHz / 9600 baud); must be >= 8
TIMEOUT_BITS, 20, idle bit-times between bytes of one word before the partial word is discarded

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
enable  input  1  receive enable; low holds the receiver idle
rx  input  1  asynchronous UART line, idle high
data  output  32  assembled word; first received byte in [7:0], fourth in [31:24]
done  output  1  level, high while data holds a freshly completed word
frame_err  output  1  one-cycle pulse on bad stop bit or inter-byte timeout
busy  output  1  high while a byte or a partial word is in progress

Behaviour:
- Reset (rst_n low, asynchronous): FSM=IDLE, byte index=0, all counters=0, rx synchroniser flops=1, data=0, done=0, frame_err=0, busy=0.
- rx passes through a 2-flop synchroniser; all decisions use the synchronised value rx_s. This adds 2 cycles of latency.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: when rx_s=0 and enable=1, go to START and clear the bit counter.
- START: at count CLKS_PER_BIT/2-1 (integer divide), sample rx_s.
  - 0: go to DATA and clear the counter. If byte index=0, clear done here. This is the only data-path way done falls.
  - 1: glitch; return to IDLE with no error.
- DATA: sample rx_s every CLKS_PER_BIT cycles, i.e. at mid-bit. Shift LSB-first into an 8-bit shift register. After the 8th sample, go to STOP.
- STOP: sample once after CLKS_PER_BIT cycles.
  - rx_s=1: write the byte into shadow word lane [index*8 +: 8].
    - If index=3: copy the shadow word to data in one cycle, set done=1, index=0.
    - Otherwise: index+1.
    - In both cases return to IDLE.
  - rx_s=0: pulse frame_err, set index=0, discard the shadow word (data unchanged), go to BREAK.
- BREAK: wait for rx_s=1, then go to IDLE.
- Inter-byte timeout: in IDLE with index>0, count cycles. At TIMEOUT_BITS*CLKS_PER_BIT cycles, pulse frame_err and set index=0. The counter clears on each start-bit detection.
- data changes only on a word completion, never mid-word. done rises in the same cycle that data updates.
- done stays high across idle time until the next word's first validated start bit, or until enable goes low.
- enable=0, at any state or mid-byte: next cycle FSM=IDLE, index=0, counters=0, done=0, no frame_err. data keeps its value. Reception restarts on the first start bit after enable returns high.
- busy = (state != IDLE) or (index != 0).
- Counter width is ceil(log2(TIMEOUT_BITS*CLKS_PER_BIT+1)). A single counter is shared by bit timing and timeout.
- No parity, and 1 stop bit only. A back-to-back start bit immediately after the stop sample is accepted.

Test Plan:
- Tests use CLKS_PER_BIT=16 and TIMEOUT_BITS=20.
- Bytes 0x78, 0x56, 0x34, 0x12 back-to-back -> data=0x12345678 and done rises 1 cycle after the 4th stop sample. frame_err never pulses. data is unchanged and done=0 during bytes 1-3.
- Second word 0xDEADBEEF sent after the first -> done falls at the first validated start bit and rises again with data=0xDEADBEEF. The old value 0x12345678 is held until then.
- 3-cycle low glitch on idle rx -> START rejects it, state returns to IDLE, done and data are unchanged, frame_err=0.
- Byte 2 sent with stop bit=0 -> one frame_err pulse, BREAK held until rx high. Then 4 valid bytes 0x01..0x04 -> data=0x04030201.
- Two bytes, then 20*16+5 idle cycles, then 4 bytes 0xAA,0xBB,0xCC,0xDD -> frame_err pulses at the timeout and data=0xDDCCBBAA.
- enable dropped mid-byte 3, then raised, then 4 bytes 0x11..0x44 -> busy=0 and done=0 while disabled, then data=0x44332211.
- rst_n asserted mid-DATA -> all outputs go to 0 immediately, without waiting for a clock edge.
